// File: rtl/bilbo_pkg.sv
// Shared definitions for the BILBO register: mode encoding and default feedback taps per width.
package bilbo_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_CLEAR  = 2'b01,
    MODE_MISR   = 2'b10,
    MODE_NORMAL = 2'b11
  } mode_e;

  // Maximal-length tap masks (bit i set means r[i] feeds the XOR).
  function automatic logic [31:0] default_poly(input int unsigned width);
    logic [31:0] poly;
    case (width)
      2:       poly = 32'h0000_0003;
      3:       poly = 32'h0000_0006;
      4:       poly = 32'h0000_000C;
      5:       poly = 32'h0000_0014;
      6:       poly = 32'h0000_0030;
      7:       poly = 32'h0000_0060;
      8:       poly = 32'h0000_00B8;
      16:      poly = 32'h0000_B400;
      32:      poly = 32'h8020_0003;
      default: poly = 32'h0000_00B8;
    endcase
    return poly;
  endfunction

endpackage

// File: rtl/bilbo_sig_ctl.sv
// Signature session control: counts MISR cycles, flags completion and compares against GOLDEN.
module bilbo_sig_ctl
  import bilbo_pkg::*;
#(
  parameter int unsigned       WIDTH  = 8,
  parameter int unsigned       CYCLES = 255,
  parameter logic [WIDTH-1:0]  GOLDEN = '0
) (
  input  logic             clock,
  input  logic             rst,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] r,
  output logic             done,
  output logic             pass
);

  localparam int unsigned      CNT_W   = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // NORMAL and SHIFT hold the session so a later MISR resumes where it left off.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    unique case (mode)
      MODE_CLEAR: begin
        cnt_d  = '0;
        done_d = 1'b0;
      end
      MODE_MISR: begin
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_MAX) done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign pass = done_q & (r == GOLDEN);

endmodule

// File: rtl/bilbo_reg.sv
// Built-in logic block observer register: NORMAL / SHIFT / CLEAR / MISR datapath.
// Define BILBO_UPDATE_EN to add a shadow register selected onto q by en.
module bilbo_reg
  import bilbo_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
  parameter int unsigned      CYCLES = 255,
  parameter logic [WIDTH-1:0] GOLDEN = '0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             b1,
  input  logic             b2,
  input  logic [WIDTH-1:0] data,
  input  logic             scan_in,
  input  logic             en,
  input  logic             update,
  output logic [WIDTH-1:0] q,
  output logic             scan_out,
  output logic             done,
  output logic             pass
);

  mode_e            mode;
  logic [WIDTH-1:0] r_q, r_d;

  assign mode = mode_e'({b1, b2});

  always_comb begin
    r_d = r_q;
    unique case (mode)
      MODE_NORMAL: r_d = data;
      MODE_SHIFT:  r_d = {r_q[WIDTH-2:0], scan_in};
      MODE_CLEAR:  r_d = SEED;
      MODE_MISR: begin
        // Signature freezes once the session completes.
        if (!done) r_d = {r_q[WIDTH-2:0], ^(r_q & POLY)} ^ data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) r_q <= '0;
    else     r_q <= r_d;
  end

  bilbo_sig_ctl #(
    .WIDTH  (WIDTH),
    .CYCLES (CYCLES),
    .GOLDEN (GOLDEN)
  ) u_sig_ctl (
    .clock (clock),
    .rst   (rst),
    .mode  (mode),
    .r     (r_q),
    .done  (done),
    .pass  (pass)
  );

  assign scan_out = r_q[WIDTH-1];

`ifdef BILBO_UPDATE_EN
  logic [WIDTH-1:0] upd_q;

  always_ff @(posedge clock) begin
    if (rst)         upd_q <= '0;
    else if (update) upd_q <= r_q;
  end

  assign q = en ? upd_q : data;
`else
  // en and update stay as pins for compatibility with the shadowed variant.
  logic unused_pins;
  assign unused_pins = en ^ update;
  assign q = r_q;
`endif

endmodule
